frame_packer: RTL and testbench

//  Upstream of the clock-crossing FIFO, in the in_clk_i domain. Wraps a valid/ready word stream

---
 rtl/frame_pkg.sv | 31 +++
 rtl/frame_out_slice.sv | 48 ++++
 rtl/frame_packer.sv | 160 ++++++++++++++++
 tb/tb_frame_packer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// ---- frame_pkg: shared state encoding and frame layout constants for frame_packer. Rev 1.0 ----
`default_nettype none

package frame_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEQ     = 3'd1,
    PAYLOAD = 3'd2,
    LEN     = 3'd3,
    CSUM    = 3'd4
  } frame_state_e;

  localparam logic [7:0] SOF_WORD_DEFAULT = 8'hA5;

  // Word positions inside a frame; payload starts at FIELD_PAYLOAD.
  localparam int FIELD_SOF     = 0;
  localparam int FIELD_SEQ     = 1;
  localparam int FIELD_PAYLOAD = 2;

`ifdef FRAME_PACKER_CSUM_EN
  localparam int TRAILER_WORDS = 2;
`else
  localparam int TRAILER_WORDS = 1;
`endif

  localparam int OVERHEAD_WORDS = FIELD_PAYLOAD + TRAILER_WORDS;

endpackage

`default_nettype wire

// File: rtl/frame_out_slice.sv
// ---- frame_out_slice: registered valid/value stage that holds its word until the sink accepts it. Rev 1.0 ----
`default_nettype none

module frame_out_slice #(
  parameter int VALUE_WIDTH = 8
) (
  input  logic                   in_clk_i,
  input  logic                   reset_n_i,
  input  logic                   produce_i,
  input  logic [VALUE_WIDTH-1:0] word_i,
  input  logic                   out_ready_i,
  output logic                   load_o,
  output logic                   out_valid_o,
  output logic [VALUE_WIDTH-1:0] out_value_o
);

  logic                   valid_q, valid_d;
  logic [VALUE_WIDTH-1:0] value_q, value_d;

  assign load_o = !valid_q || out_ready_i;

  always_comb begin
    valid_d = valid_q;
    value_d = value_q;
    if (load_o) begin
      valid_d = produce_i;
      if (produce_i) begin
        value_d = word_i;
      end
    end
  end

  always_ff @(posedge in_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q <= 1'b0;
      value_q <= '0;
    end else begin
      valid_q <= valid_d;
      value_q <= value_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_value_o = value_q;

endmodule

`default_nettype wire

// File: rtl/frame_packer.sv
// ---- frame_packer: wraps a last-delimited word stream into SOF,SEQ,payload,LEN[,CSUM] frames. Rev 1.0 ----
// ---- Define FRAME_PACKER_CSUM_EN to append the CSUM trailer word. ----
`default_nettype none

module frame_packer
  import frame_pkg::*;
#(
  parameter int                     VALUE_WIDTH = 8,
  parameter int                     MAX_PAYLOAD = 16,
  parameter logic [VALUE_WIDTH-1:0] SOF_WORD    = VALUE_WIDTH'(SOF_WORD_DEFAULT)
) (
  input  logic                   in_clk_i,
  input  logic                   reset_n_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  logic [VALUE_WIDTH-1:0] s_data_i,
  input  logic                   s_last_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [VALUE_WIDTH-1:0] out_value_o,
  output logic                   frame_done_o,
  output logic                   overflow_o
);

  localparam logic [VALUE_WIDTH-1:0] MAX_LEN = VALUE_WIDTH'(MAX_PAYLOAD);
  localparam logic [VALUE_WIDTH-1:0] ONE     = VALUE_WIDTH'(1);

  frame_state_e           state_q, state_d;
  logic [VALUE_WIDTH-1:0] seq_q, seq_d;
  logic [VALUE_WIDTH-1:0] len_q, len_d;
  logic [VALUE_WIDTH-1:0] len_inc;
  logic [VALUE_WIDTH-1:0] word;
  logic                   produce;
  logic                   load;
  logic                   frame_done_q, frame_done_d;
  logic                   overflow_q, overflow_d;
`ifdef FRAME_PACKER_CSUM_EN
  logic [VALUE_WIDTH-1:0] csum_q, csum_d;
`endif

  assign len_inc   = len_q + ONE;
  assign s_ready_o = (state_q == PAYLOAD) && load;

  always_comb begin
    state_d      = state_q;
    seq_d        = seq_q;
    len_d        = len_q;
    produce      = 1'b0;
    word         = '0;
    frame_done_d = 1'b0;
    overflow_d   = 1'b0;
`ifdef FRAME_PACKER_CSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      IDLE: begin
        // The word that opens a frame is only peeked here; PAYLOAD consumes it.
        if (load && s_valid_i) begin
          produce = 1'b1;
          word    = SOF_WORD;
          state_d = SEQ;
        end
      end
      SEQ: begin
        if (load) begin
          produce = 1'b1;
          word    = seq_q;
          len_d   = '0;
          state_d = PAYLOAD;
`ifdef FRAME_PACKER_CSUM_EN
          csum_d  = seq_q;
`endif
        end
      end
      PAYLOAD: begin
        if (load && s_valid_i) begin
          produce = 1'b1;
          word    = s_data_i;
          len_d   = len_inc;
`ifdef FRAME_PACKER_CSUM_EN
          csum_d  = csum_q + s_data_i;
`endif
          if (s_last_i || (len_inc == MAX_LEN)) begin
            state_d = LEN;
          end
          overflow_d = !s_last_i && (len_inc == MAX_LEN);
        end
      end
      LEN: begin
        if (load) begin
          produce = 1'b1;
          word    = len_q;
`ifdef FRAME_PACKER_CSUM_EN
          csum_d  = csum_q + len_q;
          state_d = CSUM;
`else
          state_d      = IDLE;
          frame_done_d = 1'b1;
          seq_d        = seq_q + ONE;
`endif
        end
      end
`ifdef FRAME_PACKER_CSUM_EN
      CSUM: begin
        if (load) begin
          produce      = 1'b1;
          word         = csum_q;
          state_d      = IDLE;
          frame_done_d = 1'b1;
          seq_d        = seq_q + ONE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge in_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      seq_q        <= '0;
      len_q        <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef FRAME_PACKER_CSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      seq_q        <= seq_d;
      len_q        <= len_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
`ifdef FRAME_PACKER_CSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  frame_out_slice #(
    .VALUE_WIDTH (VALUE_WIDTH)
  ) u_out_slice (
    .in_clk_i    (in_clk_i),
    .reset_n_i   (reset_n_i),
    .produce_i   (produce),
    .word_i      (word),
    .out_ready_i (out_ready_i),
    .load_o      (load),
    .out_valid_o (out_valid_o),
    .out_value_o (out_value_o)
  );

  assign frame_done_o = frame_done_q;
  assign overflow_o   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_packer.sv
// ---- tb_frame_packer: scoreboard bench; expected frames come from a burst-level model of the framing rules. ----
`default_nettype none

module tb_frame_packer;
  import frame_pkg::*;

  localparam int VW   = 8;
  localparam int MAXP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [VW-1:0] s_data;
  logic          s_last;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_value;
  logic          frame_done;
  logic          overflow;

  always #5 clk = ~clk;

  frame_packer #(
    .VALUE_WIDTH (VW),
    .MAX_PAYLOAD (MAXP),
    .SOF_WORD    (8'hA5)
  ) dut (
    .in_clk_i     (clk),
    .reset_n_i    (rst_n),
    .s_valid_i    (s_valid),
    .s_ready_o    (s_ready),
    .s_data_i     (s_data),
    .s_last_i     (s_last),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_value_o  (out_value),
    .frame_done_o (frame_done),
    .overflow_o   (overflow)
  );

  typedef struct packed {
    logic [7:0] v;
    logic       done;
    logic       ovf;
  } exp_t;

  exp_t expq[$];
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   seq_m    = 0;
  int   rdy_mode = 1;   // 0 random, 1 always ready, 2 stalled

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic void push_exp(input logic [7:0] v, input logic d, input logic o);
    exp_t e;
    e.v    = v;
    e.done = d;
    e.ovf  = o;
    expq.push_back(e);
  endfunction

  // A burst is cut into frames of at most MAXP words; every cut that is not the
  // burst's own end is a forced close and flags overflow on its final payload word.
  task automatic model_burst(input logic [7:0] words[$]);
    int         n;
    int         pos;
    int         take;
    logic [7:0] sum;
    logic       is_final;
    n   = words.size();
    pos = 0;
    while (pos < n) begin
      take     = (n - pos > MAXP) ? MAXP : (n - pos);
      is_final = (pos + take == n);
      sum      = seq_m[7:0];
      push_exp(SOF_WORD_DEFAULT, 1'b0, 1'b0);
      push_exp(seq_m[7:0], 1'b0, 1'b0);
      for (int i = 0; i < take; i++) begin
        sum = sum + words[pos + i];
        push_exp(words[pos + i], 1'b0, (i == take - 1) && !is_final);
      end
      sum = sum + take[7:0];
`ifdef FRAME_PACKER_CSUM_EN
      push_exp(take[7:0], 1'b0, 1'b0);
      push_exp(sum, 1'b1, 1'b0);
`else
      push_exp(take[7:0], 1'b1, 1'b0);
`endif
      seq_m = (seq_m + 1) % 256;
      pos   = pos + take;
    end
  endtask

  // Entered and left at posedge+#1.
  task automatic send_word(input logic [7:0] d, input logic last);
    bit ok;
    ok      = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_burst(input logic [7:0] words[$], input int gap);
    model_burst(words);
    for (int i = 0; i < words.size(); i++) begin
      send_word(words[i], i == words.size() - 1);
    end
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      1:       out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: a word counts as new when the previous cycle allowed a load.
  bit         prev_load = 1'b1;
  logic [7:0] last_val  = '0;
  exp_t       got_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_load = 1'b1;
    end else begin
      if (out_valid && !out_ready) check("sready_blocked", {31'd0, s_ready}, 32'd0);
      if (prev_load && out_valid) begin
        if (expq.size() == 0) begin
          check("unexpected_word", {24'd0, out_value}, 32'hFFFF_FFFF);
        end else begin
          got_e = expq.pop_front();
          check("frame_word", {22'd0, out_value, frame_done, overflow},
                {22'd0, got_e.v, got_e.done, got_e.ovf});
        end
      end else if (prev_load) begin
        check("idle_pulses", {30'd0, frame_done, overflow}, 32'd0);
      end else begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_value", {24'd0, out_value}, {24'd0, last_val});
        check("hold_pulses", {30'd0, frame_done, overflow}, 32'd0);
      end
      last_val  = out_value;
      prev_load = !out_valid || out_ready;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", expq.size());
    $fatal(1, "watchdog");
  end

  logic [7:0] w[$];
  logic [7:0] hold_seq;
  bit         seen;

  initial begin
    rst_n     = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    s_last    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_value", {24'd0, out_value}, 32'd0);
    check("reset_s_ready", {31'd0, s_ready}, 32'd0);
    check("reset_pulses", {30'd0, frame_done, overflow}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame, then an identical one to see SEQ advance.
    w = '{8'h10, 8'h20, 8'h30};
    send_burst(w, 3);
    send_burst(w, 3);

    // Six words without a delimiter: forced close after MAXP words.
    w = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_burst(w, 3);

    // Stall the sink while the SEQ word is presented.
    hold_seq = seq_m[7:0];
    w = '{8'h40, 8'h41};
    fork
      send_burst(w, 4);
      begin
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
          @(posedge clk);
          #1;
          if (out_valid && out_value == SOF_WORD_DEFAULT) begin
            seen = 1'b1;
            break;
          end
        end
        check("sof_seen", {31'd0, seen}, 32'd1);
        #1;
        rdy_mode = 2;
        @(posedge clk);
        #2;
        repeat (5) begin
          @(negedge clk);
          check("stall_seq_value", {24'd0, out_value}, {24'd0, hold_seq});
          check("stall_s_ready", {31'd0, s_ready}, 32'd0);
        end
        rdy_mode = 1;
      end
    join

    // Reset in the middle of a payload drops the partial frame and restarts SEQ.
    push_exp(SOF_WORD_DEFAULT, 1'b0, 1'b0);
    push_exp(seq_m[7:0], 1'b0, 1'b0);
    push_exp(8'h11, 1'b0, 1'b0);
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midframe_reset_valid", {31'd0, out_valid}, 32'd1 - 32'd1);
    check("midframe_queue_drained", expq.size(), 32'd0);
    expq.delete();
    seq_m = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    w = '{8'h33};
    send_burst(w, 2);

    // Randomized bursts with random back-pressure; enough frames for SEQ to wrap.
    rdy_mode = 0;
    for (int b = 0; b < 300; b++) begin
      w.delete();
      for (int i = 0; i < $urandom_range(1, 10); i++) begin
        w.push_back(8'($urandom_range(0, 255)));
      end
      send_burst(w, $urandom_range(0, 2));
    end

    rdy_mode = 1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (expq.size() == 0) break;
    end
    check("drain_empty", expq.size(), 32'd0);
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
